// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the character width used by the receiver and the default geometry
// of the receive FIFO, plus a sizing helper for the FIFO occupancy counter.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 8;
    localparam int FIFO_THRESHOLD  = 4;

    // Occupancy must represent 0..depth inclusive, so one bit more than a pointer.
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO bus.
// Groups the receiver write strobe, the consumer pop/clear controls and the
// FIFO status outputs.
//   master : receiver/consumer side (drives rx_done, rx_data, rd_en, ovr_clr)
//   slave  : FIFO side (drives rd_data, empty, full, count, overrun, rx_irq)
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
);

    logic                         rx_done;
    logic [DATA_WIDTH-1:0]        rx_data;
    logic                         rd_en;
    logic                         ovr_clr;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic                         empty;
    logic                         full;
    logic [$clog2(DEPTH):0]       count;
    logic                         overrun;
    logic                         rx_irq;

    modport master (
        output rx_done, rx_data, rd_en, ovr_clr,
        input  rd_data, empty, full, count, overrun, rx_irq
    );

    modport slave (
        input  rx_done, rx_data, rd_en, ovr_clr,
        output rd_data, empty, full, count, overrun, rx_irq
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for the receive FIFO.
// One synchronous write port and one asynchronous read port; contents are
// deliberately not reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO.
// Buffers characters from the receiver, presents the head entry
// first-word-fall-through, and flags dropped characters with a sticky overrun.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : uart_rx_fifo_if slave (rx_done/rx_data write, rd_en pop, ovr_clr,
//         rd_data, empty, full, count, overrun, rx_irq)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int THRESHOLD  = FIFO_THRESHOLD
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = fifo_cnt_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overrun_q;

    logic empty_w;
    logic full_w;
    logic pop_acc;
    logic wr_acc;
    logic ovr_evt;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(DEPTH));

    // A write while full is still accepted when a pop frees the head slot in
    // the same cycle; wr_ptr equals rd_ptr then, so the old head is read out
    // combinationally while its slot is overwritten at the edge.
    assign pop_acc = bus.rd_en && !empty_w;
    assign wr_acc  = bus.rx_done && (!full_w || pop_acc);
    assign ovr_evt = bus.rx_done && full_w && !pop_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, pop_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // Set has priority over clear so a drop is never lost.
            if (ovr_evt) begin
                overrun_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    uart_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.rx_data),
        .rd_addr (rd_ptr),
        .rd_data (bus.rd_data)
    );

    assign bus.empty   = empty_w;
    assign bus.full    = full_w;
    assign bus.count   = count_q;
    assign bus.overrun = overrun_q;
    assign bus.rx_irq  = (count_q >= CNT_W'(THRESHOLD));

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per received character.
REQ-002 SHALL have parameter DEPTH, default 8, number of storage entries; power of two, 2 to 64.
REQ-003 SHALL have parameter THRESHOLD, default 4, fill level that asserts rx_irq; range 1 to DEPTH.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous reset, active-low.
REQ-006 SHALL have port rx_done, input, 1, one-cycle pulse from receiver; write strobe.
REQ-007 SHALL have port rx_data, input, DATA_WIDTH, received character; valid in the rx_done cycle.
REQ-008 SHALL have port rd_en, input, 1, pop request from consumer.
REQ-009 SHALL have port ovr_clr, input, 1, clears the sticky overrun flag.
REQ-010 SHALL have port rd_data, output, DATA_WIDTH, head entry; first-word-fall-through.
REQ-011 SHALL have port empty, output, 1, no entries stored.
REQ-012 SHALL have port full, output, 1, DEPTH entries stored.
REQ-013 SHALL have port count, output, log2(DEPTH)+1, current number of stored entries.
REQ-014 SHALL have port overrun, output, 1, sticky; a character was dropped.
REQ-015 SHALL have port rx_irq, output, 1, count >= THRESHOLD.

Function
REQ-016 SHALL hold write pointer, read pointer and count registers; pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-017 SHALL accept a write when rx_done=1 and full=0: store rx_data at the write pointer, then increment it.
REQ-018 SHALL accept a pop when rd_en=1 and empty=0: increment the read pointer.
REQ-019 SHALL ignore rd_en while empty=1; pointers and count unchanged, no underflow.
REQ-020 SHALL drive rd_data combinationally from the entry at the read pointer; value undefined while empty=1.
REQ-021 SHALL make a written character visible on rd_data with empty=0 in the cycle after the rx_done edge; latency 1.
REQ-022 SHALL, on simultaneous accepted write and accepted pop, leave count unchanged and advance both pointers.
REQ-023 SHALL, on rx_done=1 and rd_en=1 while full=1, perform both the pop and the write, keeping full=1 and count=DEPTH, with no overrun.
REQ-024 SHALL, on rx_done=1 while full=1 and no pop, discard rx_data, leave storage and pointers unchanged, and set overrun on the next edge.
REQ-025 SHALL, on rx_done=1 while empty=1 and rd_en=1, perform the write only, so count becomes 1.
REQ-026 SHALL derive empty as count==0, full as count==DEPTH, and rx_irq as count>=THRESHOLD, all from registered count.
REQ-027 SHALL clear overrun on ovr_clr=1; if ovr_clr and a new overrun event occur in the same cycle, overrun SHALL remain 1 (set wins).
REQ-028 SHALL keep count within 0..DEPTH under all input combinations.

Reset
REQ-029 SHALL, while rst=0, asynchronously force the pointers and count to 0, overrun to 0, empty to 1, full to 0, and rx_irq to 0.
REQ-030 SHALL not reset storage contents; rd_data is undefined after reset until the first write.
REQ-031 SHALL, on reset asserted mid-operation, discard all stored entries; the first write after release SHALL appear at entry 0.

Structure
REQ-032 SHALL take the DATA_WIDTH and DEPTH defaults from the shared package uart_pkg, which also holds UART_DATA_WIDTH used by the receiver.
REQ-033 SHALL place the storage array in sub-module uart_rx_fifo_mem: a write port plus an asynchronous read port, with no reset.
REQ-034 SHALL keep the pointer, count and flag logic in uart_rx_fifo; the implementation is no more than about 200 RTL lines.

Verification
REQ-035 Bench SHALL, after reset, pulse rx_done with 0xA5 and check rd_data=0xA5, empty=0 and count=1 one cycle later; then pulse rd_en and check empty=1.
REQ-036 Bench SHALL write 8 characters 0x01..0x08 with no reads and check full=1 and count=8; then pop 8 and check the outputs are 0x01..0x08 in order.
REQ-037 Bench SHALL fill to 8, write 0xFF, and check overrun=1, count=8 and the head still 0x01; then pulse ovr_clr and check overrun=0.
REQ-038 Bench SHALL, while full, assert rx_done=0x55 and rd_en together and check overrun=0, count=8, and 0x55 as the eighth pop thereafter.
REQ-039 Bench SHALL write 4 entries and check rx_irq=1 at count=4 and rx_irq=0 after one pop; then assert rst=0 mid-stream and check count=0 and empty=1 immediately.
REQ-040 Bench SHALL run 20 wrap-around cycles of alternating write and read and check that data order is preserved and count stays at 0 or 1.
